// File: rtl/enigma_cipher.sv
// enigma_cipher: one-stage-per-clock Enigma letter path (rotors 3,2,1, reflector, rotors 1,2,3).
// Define ENIGMA_STEP_EN to add the STEP/WAIT states that pulse `rotate` before each letter.
module enigma_cipher #(
  parameter int ALPHA = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_letter,
  output logic       rotate,
  input  logic [4:0] rotor1,
  input  logic [4:0] rotor2,
  input  logic [4:0] rotor3,
  input  logic [2:0] rotor_type_1,
  input  logic [2:0] rotor_type_2,
  input  logic [2:0] rotor_type_3,
  input  logic [4:0] ring_position_1,
  input  logic [4:0] ring_position_2,
  input  logic [4:0] ring_position_3,
  input  logic       reflector_type,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_letter,
  output logic       busy
);

  localparam logic [5:0] MOD = 6'(ALPHA);
  localparam logic [8*26-1:0] WIRE_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [8*26-1:0] WIRE_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [8*26-1:0] WIRE_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [8*26-1:0] WIRE_IV  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
  localparam logic [8*26-1:0] WIRE_V   = "VZBRGITYUPSDNHLMXAKFQJWOEC";
  localparam logic [8*26-1:0] UKW_B    = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  localparam logic [8*26-1:0] UKW_C    = "FVPJIAOYEDRZXWGCTKUQSBNLHM";

`ifdef ENIGMA_STEP_EN
  typedef enum logic [3:0] {IDLE, STEP, WAIT, F3, F2, F1, RF, B1, B2, B3, DONE} state_e;
`else
  typedef enum logic [3:0] {IDLE, F3, F2, F1, RF, B1, B2, B3, DONE} state_e;
`endif

  // Sums stay below 52, so one conditional subtract brings them back into range.
  function automatic logic [4:0] mod_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= MOD) t = t - MOD;
    return t[4:0];
  endfunction

  function automatic logic [4:0] mod_sub(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] t;
    t = {1'b0, a} + MOD - {1'b0, b};
    if (t >= MOD) t = t - MOD;
    return t[4:0];
  endfunction

  // Tables are ASCII strings: first character is the image of letter 0.
  function automatic logic [4:0] table_lookup(input logic [8*26-1:0] tbl, input logic [4:0] s);
    logic [7:0] ch;
    if (s > 5'd25) return s;
    ch = tbl[8*(25 - int'(s)) +: 8] - 8'd65;
    return ch[4:0];
  endfunction

  function automatic logic [4:0] fwd_wire(input logic [2:0] t, input logic [4:0] s);
    case (t)
      3'd0:    return table_lookup(WIRE_I, s);
      3'd1:    return table_lookup(WIRE_II, s);
      3'd2:    return table_lookup(WIRE_III, s);
      3'd3:    return table_lookup(WIRE_IV, s);
      3'd4:    return table_lookup(WIRE_V, s);
      default: return s;
    endcase
  endfunction

  function automatic logic [4:0] inv_wire(input logic [2:0] t, input logic [4:0] s);
    logic [4:0] r;
    r = s;
    for (int i = 0; i < 26; i++)
      if (fwd_wire(t, 5'(i)) == s) r = 5'(i);
    return r;
  endfunction

  function automatic logic [4:0] reflect(input logic sel, input logic [4:0] x);
    return sel ? table_lookup(UKW_C, x) : table_lookup(UKW_B, x);
  endfunction

  state_e     state_q;
  logic [4:0] x_q, x_d;
  logic [4:0] pos, ring, s_idx, w;
  logic [2:0] rtype;
  logic       backward;
  logic       in_ready_q, out_valid_q, busy_q;
  logic [4:0] out_letter_q;

  always_comb begin
    pos   = rotor3;
    ring  = ring_position_3;
    rtype = rotor_type_3;
    case (state_q)
      F2, B2: begin
        pos   = rotor2;
        ring  = ring_position_2;
        rtype = rotor_type_2;
      end
      F1, B1: begin
        pos   = rotor1;
        ring  = ring_position_1;
        rtype = rotor_type_1;
      end
      default: ;
    endcase
    backward = (state_q == B1) || (state_q == B2) || (state_q == B3);
    s_idx    = mod_sub(mod_add(x_q, pos), ring);
    w        = backward ? inv_wire(rtype, s_idx) : fwd_wire(rtype, s_idx);
    x_d      = (state_q == RF) ? reflect(reflector_type, x_q) : mod_add(mod_sub(w, pos), ring);
  end

  // Working letter is pure data and carries no reset.
  always_ff @(posedge clock) begin
    if (state_q == IDLE && in_valid && in_ready_q) x_q <= in_letter;
    else if (state_q inside {F3, F2, F1, RF, B1, B2, B3}) x_q <= x_d;
  end

`ifdef ENIGMA_STEP_EN
  logic rotate_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_letter_q <= '0;
      busy_q       <= 1'b0;
`ifdef ENIGMA_STEP_EN
      rotate_q     <= 1'b0;
`endif
    end else begin
`ifdef ENIGMA_STEP_EN
      rotate_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if ({1'b0, in_letter} >= MOD) begin
              out_letter_q <= in_letter;
              out_valid_q  <= 1'b1;
              state_q      <= DONE;
            end else begin
`ifdef ENIGMA_STEP_EN
              rotate_q <= 1'b1;
              state_q  <= STEP;
`else
              state_q  <= F3;
`endif
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
`ifdef ENIGMA_STEP_EN
        STEP: state_q <= WAIT;
        WAIT: state_q <= F3;
`endif
        F3: state_q <= F2;
        F2: state_q <= F1;
        F1: state_q <= RF;
        RF: state_q <= B1;
        B1: state_q <= B2;
        B2: state_q <= B3;
        B3: begin
          out_letter_q <= x_d;
          out_valid_q  <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_letter = out_letter_q;
  assign busy       = busy_q;
`ifdef ENIGMA_STEP_EN
  assign rotate = rotate_q;
`else
  assign rotate = 1'b0;
`endif

endmodule

// File: tb/tb_enigma_cipher.sv
// Bench for enigma_cipher: acts as the rotor stepping block and checks every letter
// against a string-table Enigma model; works with or without ENIGMA_STEP_EN.
module tb_enigma_cipher;
`ifdef ENIGMA_STEP_EN
  localparam int STEP_ON = 1;
`else
  localparam int STEP_ON = 0;
`endif
  localparam int LAT = (STEP_ON != 0) ? 10 : 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid, in_ready, rotate, reflector_type, out_valid, out_ready, busy;
  logic [4:0] in_letter, out_letter, rotor1, rotor2, rotor3;
  logic [4:0] ring_position_1, ring_position_2, ring_position_3;
  logic [2:0] rotor_type_1, rotor_type_2, rotor_type_3;
  int         p1 = 0, p2 = 0, p3 = 0;
  int         n_tests = 0, n_fail = 0, rot_seen = 0;

  string ROT [5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                     "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                     "VZBRGITYUPSDNHLMXAKFQJWOEC"};
  string REFL [2] = '{"YRUHQSLDPXNGOKMIEBFZCWVJAT", "FVPJIAOYEDRZXWGCTKUQSBNLHM"};
  string NOTCH = "QEVJZ";

  assign rotor1 = 5'(p1);
  assign rotor2 = 5'(p2);
  assign rotor3 = 5'(p3);

  always #5 clock = ~clock;

  enigma_cipher #(.ALPHA(26)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_letter(in_letter), .rotate(rotate), .rotor1(rotor1), .rotor2(rotor2),
    .rotor3(rotor3), .rotor_type_1(rotor_type_1), .rotor_type_2(rotor_type_2),
    .rotor_type_3(rotor_type_3), .ring_position_1(ring_position_1),
    .ring_position_2(ring_position_2), .ring_position_3(ring_position_3),
    .reflector_type(reflector_type), .out_valid(out_valid), .out_ready(out_ready),
    .out_letter(out_letter), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_tests++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit at_notch(input int t, input int p);
    if (t >= 5) return 1'b0;
    return p == (int'(NOTCH[t]) - 65);
  endfunction

  // Rotor stepping block with the middle-rotor double step.
  task automatic step_model(inout int a, inout int b, inout int c);
    bit mid, right;
    mid   = at_notch(int'(rotor_type_2), b);
    right = at_notch(int'(rotor_type_3), c);
    if (mid) begin
      a = (a + 1) % 26;
      b = (b + 1) % 26;
    end else if (right) begin
      b = (b + 1) % 26;
    end
    c = (c + 1) % 26;
  endtask

  function automatic int pass_rotor(input int x, input int t, input int p, input int r, input bit inv);
    int s, w;
    s = ((x + p - r) % 26 + 26) % 26;
    w = s;
    if (t < 5) begin
      if (!inv) w = int'(ROT[t][s]) - 65;
      else for (int i = 0; i < 26; i++) if (int'(ROT[t][i]) - 65 == s) w = i;
    end
    return ((w - p + r) % 26 + 26) % 26;
  endfunction

  function automatic int model(input int x, input int q1, input int q2, input int q3);
    int v;
    v = pass_rotor(x, int'(rotor_type_3), q3, int'(ring_position_3), 1'b0);
    v = pass_rotor(v, int'(rotor_type_2), q2, int'(ring_position_2), 1'b0);
    v = pass_rotor(v, int'(rotor_type_1), q1, int'(ring_position_1), 1'b0);
    v = int'(REFL[int'(reflector_type)][v]) - 65;
    v = pass_rotor(v, int'(rotor_type_1), q1, int'(ring_position_1), 1'b1);
    v = pass_rotor(v, int'(rotor_type_2), q2, int'(ring_position_2), 1'b1);
    v = pass_rotor(v, int'(rotor_type_3), q3, int'(ring_position_3), 1'b1);
    return v;
  endfunction

  // One clock; the rotor block reacts to a rotate pulse seen in this cycle.
  task automatic tick();
    @(negedge clock);
    if (rotate === 1'b1) begin
      rot_seen++;
      step_model(p1, p2, p3);
    end
  endtask

  task automatic send(input int letter, input int stall, output int got);
    int  q1, q2, q3, e, k, r0, r1;
    bit  busy_ok, hold_ok;
    q1 = p1; q2 = p2; q3 = p3;
    if (letter < 26) begin
      step_model(q1, q2, q3);
      if (STEP_ON == 0) begin
        p1 = q1; p2 = q2; p3 = q3;
      end
      e = model(letter, q1, q2, q3);
    end else begin
      e = letter;
    end
    out_ready = (stall == 0);
    k = 0;
    while (in_ready !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("in_ready", 32'(in_ready), 1);
    r0 = rot_seen;
    in_valid  = 1'b1;
    in_letter = 5'(letter);
    tick();
    in_valid = 1'b0;
    r1 = rot_seen - r0;
    k = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && k < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      k++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    chk("latency", 32'(k), (letter < 26) ? LAT : 1);
    chk("busy", 32'(busy_ok), 1);
    chk("rotate_T+1", 32'(r1), (letter < 26) ? STEP_ON : 0);
    chk("out_letter", 32'(out_letter), e);
    got = int'(out_letter);
    hold_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_letter !== 5'(e) || in_ready !== 1'b0 || busy !== 1'b1)
        hold_ok = 1'b0;
    end
    if (stall > 0) chk("hold", 32'(hold_ok), 1);
    out_ready = 1'b1;
    tick();
    chk("done_exit", 32'({out_valid, busy, in_ready}), 1);
    chk("rotate_count", 32'(rot_seen - r0), (letter < 26) ? STEP_ON : 0);
  endtask

  initial begin
    int    got, letter, s1, s2, s3;
    string cipher;
    cipher = "BDZGO";
    in_valid = 1'b0; in_letter = '0; out_ready = 1'b1;
    rotor_type_1 = 3'd0; rotor_type_2 = 3'd1; rotor_type_3 = 3'd2;
    ring_position_1 = '0; ring_position_2 = '0; ring_position_3 = '0;
    reflector_type = 1'b0;

    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_rotate", 32'(rotate), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_letter", 32'(out_letter), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    tick();
    chk("in_ready_after_rst", 32'(in_ready), 1);

    for (int i = 0; i < 5; i++) begin
      send(0, 0, got);
      chk("ref_vector", 32'(got), int'(cipher[i]) - 65);
    end
`ifdef ENIGMA_STEP_EN
    chk("ref_pos1", 32'(p1), 0);
    chk("ref_pos2", 32'(p2), 0);
    chk("ref_pos3", 32'(p3), 5);
`endif

    p1 = 0; p2 = 0; p3 = 0;
    for (int i = 0; i < 5; i++) begin
      send(int'(cipher[i]) - 65, 0, got);
      chk("reciprocity", 32'(got), 0);
    end

    send(0, 20, got);

    s1 = p1; s2 = p2; s3 = p3;
    send(27, 0, got);
    chk("pass_through", 32'(got), 27);
`ifdef ENIGMA_STEP_EN
    chk("pass_pos", 32'({8'(p1), 8'(p2), 8'(p3)}), (s1 << 16) | (s2 << 8) | s3);
`endif

    in_valid = 1'b1; in_letter = 5'd7;
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_cut_rotate", 32'(rotate), 0);
    chk("rst_cut_busy", 32'(busy), 0);
    tick();
    reset = 1'b1;
    tick();

    in_valid = 1'b1; in_letter = 5'd11;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    #1;
    chk("midop_in_ready", 32'(in_ready), 0);
    chk("midop_rotate", 32'(rotate), 0);
    chk("midop_out_valid", 32'(out_valid), 0);
    chk("midop_out_letter", 32'(out_letter), 0);
    chk("midop_busy", 32'(busy), 0);
    tick();
    reset = 1'b1;
    tick();
    send(11, 0, got);

    for (int n = 0; n < 48; n++) begin
      if (n % 8 == 0) begin
        rotor_type_1 = 3'($urandom_range(0, 7));
        rotor_type_2 = 3'($urandom_range(0, 7));
        rotor_type_3 = 3'($urandom_range(0, 7));
        ring_position_1 = 5'($urandom_range(0, 25));
        ring_position_2 = 5'($urandom_range(0, 25));
        ring_position_3 = 5'($urandom_range(0, 25));
        reflector_type = 1'($urandom_range(0, 1));
        p1 = int'($urandom_range(0, 25));
        p2 = int'($urandom_range(0, 25));
        p3 = int'($urandom_range(0, 25));
      end
      letter = ($urandom_range(0, 9) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 25));
      send(letter, int'($urandom_range(0, 3)), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/enigma_cipher.md
# enigma_cipher

Letter-path engine of the Enigma core. It sits downstream of the rotor stepping block `rotor`, which it drives with `rotate` and whose `rotor1..3` positions it reads. It accepts one plaintext letter per transaction, optionally steps the rotors first, and walks the letter through three rotors, the reflector and back. It runs sequentially, one stage per clock, and returns the cipher letter on a valid/ready output.

## Interface
- `ALPHA`, default 26: alphabet size; letters are 0..25, where 0 is 'A'.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `in_valid` in 1: plaintext letter offered.
- `in_ready` out 1: engine idle and accepts a letter.
- `in_letter` in 5: plaintext letter.
- `rotate` out 1: one-cycle step pulse to the `rotor` block.
- `rotor1`, `rotor2`, `rotor3` in 5 each: current rotor window positions. `rotor3` is the fast, rightmost rotor.
- `rotor_type_1..3` in 3 each: rotor types. 0..4 select I..V; 5..7 select identity wiring.
- `ring_position_1..3` in 5 each: ring settings, 0..25.
- `reflector_type` in 1: 0 selects UKW-B, 1 selects UKW-C.
- `out_valid` out 1: cipher letter available.
- `out_ready` in 1: downstream accepts the letter.
- `out_letter` out 5: cipher letter.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **FSM states:** IDLE, STEP, WAIT, F3, F2, F1, RF, B1, B2, B3, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`, latch `in_letter` into the working register `x`.
  - If `in_letter` < 26, go to STEP.
  - If `in_letter` ≥ 26, pass through: `out_letter` = `in_letter`, no rotate, go to DONE.
- **STEP:** `rotate`=1 for exactly this cycle. Go to WAIT.
- **WAIT:** one idle cycle so the `rotor` block's updated positions settle. Go to F3.
- **Forward stages F3, F2, F1:** use rotor n with position p and ring r.
  - s = (x + p − r) mod 26
  - w = WIRE[type][s]
  - x ← (w − p + r) mod 26
- **RF:** x ← REFL[reflector_type][x].
- **Backward stages B1, B2, B3:** same as forward, but with the inverse wiring, INV[type][s].
- **Modular arithmetic:** done in 6-bit. Add 26 before subtracting so the value never goes negative, then reduce with one conditional subtract of 26 (add, sub) or two (add then sub).
- **Forward wirings (I..V):**
  - I: EKMFLGDQVZNTOWYHXUSPAIBRCJ
  - II: AJDKSIRUXBLHWTMCQGZNPYFVOE
  - III: BDFHJLCPRTXVZNYEIWGAKMUSQO
  - IV: ESOVPZJAYQUIRHXLNFTGKDCMWB
  - V: VZBRGITYUPSDNHLMXAKFQJWOEC
  - Inverse tables are the exact inverses.
- **Reflectors:**
  - B: YRUHQSLDPXNGOKMIEBFZCWVJAT
  - C: FVPJIAOYEDRZXWGCTKUQSBNLHM
- **Sampling:** all configuration inputs and rotor positions are sampled live in each stage. They must stay stable during a transaction.
- **DONE:**
  - `out_valid`=1 and `out_letter`=x, both held stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
  - IDLE accepts a new letter at the earliest one cycle later; there is no same-cycle reaccept.

## Timing
- **Reset values:**
  - `in_ready`=0 while `reset` is asserted, and 1 from the first cycle after release.
  - `rotate`=0, `out_valid`=0, `out_letter`=0, `busy`=0, state=IDLE.
- **Latency** (input handshake at cycle T):
  - `rotate` is high in cycle T+1.
  - F3 evaluates in T+3.
  - `out_valid` rises in T+10.
  - Pass-through letters: `out_valid` rises in T+1.
- **Output backpressure:** holding `out_ready`=0 stalls in DONE indefinitely. No further `rotate` is issued and `in_ready` stays 0.
- **Reset mid-transaction:** asynchronous return to IDLE. The letter is discarded. If reset cuts a pulse, `rotate` drops immediately.
- **Step count:** at most one `rotate` pulse per accepted letter. No pulse is ever issued outside STEP.

## Configuration
- **`ENIGMA_STEP_EN` defined:** behaviour as above. The engine steps the rotors before every valid letter.
- **`ENIGMA_STEP_EN` undefined:**
  - STEP and WAIT are removed and IDLE goes directly to F3.
  - `rotate` is tied to 0, so stepping is external.
  - Latency to `out_valid` becomes T+8.

## Test plan
- **Reference vector:**
  - Setup: types 1=I, 2=II, 3=III; rings 0; reflector B; `rotor` block reset to AAA; `out_ready`=1.
  - Stimulus: send AAAAA.
  - Required: output BDZGO; positions after the run are rotor1=A, rotor2=A, rotor3=F.
- **Reciprocity:** reset the rotors to AAA, then send BDZGO. Required: output AAAAA.
- **Latency and pulse:**
  - Stimulus: single letter A.
  - Required: `rotate` high for exactly cycle T+1; `out_valid` at T+10; `busy` high T+1..T+10.
- **Backpressure:**
  - Stimulus: `out_ready`=0 for 20 cycles after `out_valid`.
  - Required: `out_letter` stable, `in_ready`=0, no extra `rotate`; completes the cycle `out_ready` rises.
- **Pass-through:**
  - Stimulus: `in_letter`=27.
  - Required: `out_letter`=27 at T+1; `rotate` never asserted; positions unchanged.
- **Reset mid-op:**
  - Stimulus: assert `reset` at T+5.
  - Required: all outputs at reset values within the same cycle; the next letter processes normally.
